// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised up/down counter family.
// No logic; pure declarations.
// Imported by param_updown_counter and anything that drives its direction pin.
package counter_pkg;

   // Counter control state: RUN counts, HALT is the one-shot terminal park
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   // Encodings of the up_dn pin
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/param_updown_counter.sv
// Loadable up/down modulo counter with count enable, one-shot halt and tc/wrap/done status.
// Latency: load and count steps visible on count one edge after sampling; tc is combinational.
// Backpressure: en=0 stalls the count (wrap drops); load and rst are always accepted.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MOD_MAX   = 15,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             up_dn,
   input  logic             oneshot,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO_V  = '0;
   localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

   // Reject parameter sets whose count range cannot be represented
   if (WIDTH < 1) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be at least 1");
   end
   if ((MOD_MAX < 1) || (longint'(MOD_MAX) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_mod
      $error("param_updown_counter: MOD_MAX out of range 1..2^WIDTH-1");
   end
   if ((RESET_VAL < 0) || (RESET_VAL > MOD_MAX)) begin : g_bad_reset
      $error("param_updown_counter: RESET_VAL must lie in 0..MOD_MAX");
   end

   state_t           state;
   logic             at_term;
   logic [WIDTH-1:0] step_cnt;
   logic [WIDTH-1:0] load_val;

   // Next-count arithmetic: the terminal is detected explicitly so the wrap target is
   // chosen here rather than relying on natural 2^WIDTH overflow; loads saturate at MOD_MAX
   always_comb begin
      at_term  = 1'b0;
      step_cnt = count;
      load_val = data;
      if (up_dn == DIR_UP) begin
         at_term  = (count == MAX_V);
         step_cnt = at_term ? ZERO_V : (count + ONE_V);
      end else begin
         at_term  = (count == ZERO_V);
         step_cnt = at_term ? MAX_V : (count - ONE_V);
      end
      if (data > MAX_V) begin
         load_val = MAX_V;
      end
   end

   // Terminal count tracks up_dn directly so a direction flip shows up in the same cycle
   assign tc = at_term;

   // Control FSM with registered count/wrap/done; load overrides counting and exits HALT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         count <= RESET_V;
         wrap  <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         state <= RUN;
         count <= load_val;
         wrap  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (en) begin
                  if (at_term && oneshot) begin
                     // Park on the terminal value instead of wrapping
                     state <= HALT;
                     done  <= 1'b1;
                     wrap  <= 1'b0;
                  end else begin
                     count <= step_cnt;
                     wrap  <= at_term;
                  end
               end else begin
                  wrap <= 1'b0;
               end
            end
            HALT: begin
               // Only load or rst leaves HALT; en/up_dn/oneshot are ignored here
               wrap <= 1'b0;
               done <= 1'b1;
            end
            default: begin
               state <= RUN;
               wrap  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a default 0..15 instance and a 0..9 instance (RESET_VAL=3)
// share every input; each is tracked by an arithmetic reference model.
// Directed scenarios are followed by a randomized run.
module tb_param_updown_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] data;
   logic       up_dn;
   logic       oneshot;

   logic [3:0] cnt0, cnt1;
   logic       tc0, tc1, wrap0, wrap1, done0, done1;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state per instance
   int modv[2] = '{15, 9};
   int resv[2] = '{0, 3};
   int m_cnt[2];
   bit m_wrap[2];
   bit m_done[2];

   param_updown_counter dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
      .up_dn(up_dn), .oneshot(oneshot),
      .count(cnt0), .tc(tc0), .wrap(wrap0), .done(done0)
   );

   param_updown_counter #(.WIDTH(4), .MOD_MAX(9), .RESET_VAL(3)) dut9 (
      .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
      .up_dn(up_dn), .oneshot(oneshot),
      .count(cnt1), .tc(tc1), .wrap(wrap1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {count, wrap, done, tc} of an instance
   function automatic logic [6:0] act(input int k);
      if (k == 0) return {cnt0, wrap0, done0, tc0};
      return {cnt1, wrap1, done1, tc1};
   endfunction

   // Expected {count, wrap, done, tc}; tc is derived from the model count and live up_dn
   function automatic logic [6:0] exp_vec(input int k);
      logic t;
      t = (up_dn && m_cnt[k] == modv[k]) || (!up_dn && m_cnt[k] == 0);
      return {4'(m_cnt[k]), m_wrap[k], m_done[k], t};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]  = resv[k];
         m_wrap[k] = 1'b0;
         m_done[k] = 1'b0;
      end
   endtask

   // One clock edge of the behavioural rules: load > halted > enabled step > idle
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int nxt;
         if (load) begin
            m_cnt[k]  = (int'(data) > modv[k]) ? modv[k] : int'(data);
            m_wrap[k] = 1'b0;
            m_done[k] = 1'b0;
         end else if (m_done[k]) begin
            m_wrap[k] = 1'b0;
         end else if (en) begin
            nxt = up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
            if (nxt >= 0 && nxt <= modv[k]) begin
               m_cnt[k]  = nxt;
               m_wrap[k] = 1'b0;
            end else if (oneshot) begin
               m_done[k] = 1'b1;
               m_wrap[k] = 1'b0;
            end else begin
               m_cnt[k]  = up_dn ? 0 : modv[k];
               m_wrap[k] = 1'b1;
            end
         end else begin
            m_wrap[k] = 1'b0;
         end
      end
   endtask

   // Drive inputs, take one rising edge, advance the model, return at the falling edge
   task automatic step(input logic l, input logic [3:0] d, input logic e,
                       input logic u, input logic o);
      load = l; data = d; en = e; up_dn = u; oneshot = o;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (act(k) !== exp_vec(k))
            $display("FAIL reset_async inst%0d: got cnt/wrap/done/tc=%h want %h", k, act(k), exp_vec(k));
         else n_pass++;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (act(k) !== exp_vec(k))
            $display("FAIL reset_held inst%0d: got %h want %h", k, act(k), exp_vec(k));
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   task automatic test_up_wrap();
      int seq[7] = '{11, 12, 13, 14, 15, 0, 1};
      step(1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (cnt0 !== 4'd10) $display("FAIL up_load got %0d want 10", cnt0);
      else n_pass++;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
         n_checks++;
         if ({cnt0, wrap0, tc0} !== {4'(seq[i]), seq[i] == 0, seq[i] == 15})
            $display("FAIL up_seq step%0d got cnt/wrap/tc=%0d/%b/%b want %0d/%b/%b",
                     i, cnt0, wrap0, tc0, seq[i], seq[i] == 0, seq[i] == 15);
         else n_pass++;
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act(k) !== exp_vec(k))
               $display("FAIL up_model inst%0d step%0d: got %h want %h", k, i, act(k), exp_vec(k));
            else n_pass++;
         end
      end
   endtask

   task automatic test_down_wrap();
      int seq[4] = '{1, 0, 15, 14};
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if ({cnt0, wrap0, tc0} !== {4'(seq[i]), seq[i] == 15, seq[i] == 0})
            $display("FAIL dn_seq step%0d got cnt/wrap/tc=%0d/%b/%b want %0d/%b/%b",
                     i, cnt0, wrap0, tc0, seq[i], seq[i] == 15, seq[i] == 0);
         else n_pass++;
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act(k) !== exp_vec(k))
               $display("FAIL dn_model inst%0d step%0d: got %h want %h", k, i, act(k), exp_vec(k));
            else n_pass++;
         end
      end
   endtask

   task automatic test_oneshot();
      step(1'b1, 4'd13, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         // after the terminal, scramble the ignored controls while halted
         if (i < 3) step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
         else step(1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
         if (i >= 2) begin
            n_checks++;
            if ({cnt0, done0, wrap0} !== {4'd15, 1'b1, 1'b0})
               $display("FAIL os_halt step%0d got cnt/done/wrap=%0d/%b/%b want 15/1/0", i, cnt0, done0, wrap0);
            else n_pass++;
         end
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act(k) !== exp_vec(k))
               $display("FAIL os_model inst%0d step%0d: got %h want %h", k, i, act(k), exp_vec(k));
            else n_pass++;
         end
      end
      step(1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({cnt0, done0} !== {4'd3, 1'b0}) $display("FAIL os_reload got cnt/done=%0d/%b want 3/0", cnt0, done0);
      else n_pass++;
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (act(k) !== exp_vec(k))
            $display("FAIL os_resume inst%0d: got %h want %h", k, act(k), exp_vec(k));
         else n_pass++;
      end
   endtask

   task automatic test_clamp_load();
      step(1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({cnt0, cnt1} !== {4'd15, 4'd9}) $display("FAIL clamp got %0d/%0d want 15/9", cnt0, cnt1);
      else n_pass++;
      step(1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({cnt0, cnt1, wrap0, wrap1} !== {4'd4, 4'd4, 2'b00})
         $display("FAIL load_wins got cnt=%0d/%0d wrap=%b%b want 4/4 00", cnt0, cnt1, wrap0, wrap1);
      else n_pass++;
      step(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({cnt1, wrap1, cnt0, wrap0} !== {4'd0, 1'b1, 4'd10, 1'b0})
         $display("FAIL mod9_wrap got %0d/%b %0d/%b want 0/1 10/0", cnt1, wrap1, cnt0, wrap0);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      #3 rst = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (act(k) !== exp_vec(k))
            $display("FAIL rst_mid inst%0d: got %h want %h", k, act(k), exp_vec(k));
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({cnt0, cnt1} !== {4'd1, 4'd4}) $display("FAIL rst_restart got %0d/%0d want 1/4", cnt0, cnt1);
      else n_pass++;
      // reset while parked in HALT must clear done at once
      step(1'b1, 4'd14, 1'b0, 1'b1, 1'b1);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({done0, done1} !== 2'b11) $display("FAIL rst_pre_halt got done=%b%b want 11", done0, done1);
      else n_pass++;
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({done0, done1, cnt0, cnt1} !== {2'b00, 4'd0, 4'd3})
         $display("FAIL rst_halt got done=%b%b cnt=%0d/%0d want 00 0/3", done0, done1, cnt0, cnt1);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_hold_dir();
      step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({cnt0, wrap0} !== {4'd5, 1'b0}) $display("FAIL hold step%0d got %0d want 5", i, cnt0);
         else n_pass++;
      end
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({cnt0, cnt1} !== {4'd4, 4'd4}) $display("FAIL dir_flip got %0d/%0d want 4/4", cnt0, cnt1);
      else n_pass++;
      step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({tc0, tc1} !== 2'b00) $display("FAIL tc_up_at0 got %b%b want 00", tc0, tc1);
      else n_pass++;
      up_dn = 1'b0;
      #1;
      n_checks++;
      if ({tc0, tc1} !== 2'b11) $display("FAIL tc_comb_dn got %b%b want 11", tc0, tc1);
      else n_pass++;
      up_dn = 1'b1;
      #1;
      n_checks++;
      if ({tc0, tc1} !== 2'b00) $display("FAIL tc_comb_up got %b%b want 00", tc0, tc1);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0));
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act(k) !== exp_vec(k))
               $display("FAIL rand inst%0d step%0d: got cnt/wrap/done/tc=%h want %h", k, i, act(k), exp_vec(k));
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; data = 4'd0; up_dn = 1'b0; oneshot = 1'b0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_oneshot();
      test_clamp_load();
      test_async_reset();
      test_hold_dir();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
